// File: rtl/lfsr_rr_ctrl_if.sv
// Request/grant bundle between requesters and the shared LFSR controller.
interface lfsr_rr_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic             seed_we;
  logic [WIDTH-1:0] seed;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] rnd;
  logic             rnd_vld;
  logic             busy;

  modport master (
    output req, seed_we, seed,
    input  gnt, rnd, rnd_vld, busy
  );

  modport slave (
    input  req, seed_we, seed,
    output gnt, rnd, rnd_vld, busy
  );
endinterface

// File: rtl/lfsr_rr_ctrl.sv
// Two-port round-robin controller around a shared Galois LFSR. A granted
// requester gets STEPS fresh LFSR advances, then a one-cycle gnt/rnd_vld pulse.
module lfsr_rr_ctrl #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
  parameter int               STEPS = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  lfsr_rr_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STEP    = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

  // Countdown preload: STEPS advances means STEPS-1 down to 0 inclusive.
  localparam logic [3:0] CNT_INIT = 4'(STEPS - 1);

  logic [WIDTH-1:0] r_lfsr;
  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_last;
  logic             r_owner;
  logic [WIDTH-1:0] r_rnd;

  logic [WIDTH-1:0] w_lfsr_next;
  logic             w_win;
  logic [WIDTH-1:0] w_seed_safe;

  // One Galois step: shift left, fold taps back in when the MSB falls out.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    lfsr_step = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? TAPS : '0);
  endfunction

  // Zero would lock the LFSR forever, so a zero seed is replaced by all-ones.
  function automatic logic [WIDTH-1:0] seed_guard(input logic [WIDTH-1:0] s);
    seed_guard = (s == '0) ? '1 : s;
  endfunction

  assign w_lfsr_next = lfsr_step(r_lfsr);
  assign w_seed_safe = seed_guard(bus.seed);

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_win = 1'b0;
    unique case (bus.req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  // Control FSM plus LFSR, step counter, owner tracking and delivered value.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_lfsr  <= '1;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_rnd   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // A seed write takes priority and swallows any same-cycle request.
          if (bus.seed_we) begin
            r_lfsr <= w_seed_safe;
          end else if (bus.req != 2'b00) begin
            r_owner <= w_win;
            r_cnt   <= CNT_INIT;
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_lfsr <= w_lfsr_next;
          if (r_cnt == 4'd0) begin
            r_rnd   <= w_lfsr_next;
            r_state <= ST_DELIVER;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DELIVER: begin
          r_last  <= r_owner;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs come only from registered state so reset clears them at once.
  assign bus.gnt     = (r_state == ST_DELIVER) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rnd_vld = (r_state == ST_DELIVER);
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.rnd     = r_rnd;

endmodule

// File: doc/lfsr_rr_ctrl.md
# lfsr_rr_ctrl

Controller and two-port round-robin arbiter for a shared Galois LFSR pseudo-random generator. Requesters raise a level request. The block grants one requester, advances the LFSR a fixed number of steps, then delivers the fresh value with a one-cycle grant/valid pulse. It also handles seed loading and zero-lock protection, so requesters never drive the LFSR directly.

## Interface
Parameters:
- WIDTH, 4: LFSR and output width.
- TAPS, 4'b0011: Galois feedback mask (x^4+x+1, period 15). Must be WIDTH bits.
- STEPS, 4: LFSR advances per delivered value. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- req  input  2  level request per requester; held high until its gnt pulse.
- seed_we  input  1  seed write strobe; honoured only in IDLE.
- seed  input  WIDTH  seed value loaded on seed_we.
- gnt  output  2  one-hot, one-cycle grant pulse coinciding with rnd_vld.
- rnd  output  WIDTH  last delivered random value; held between deliveries.
- rnd_vld  output  1  one-cycle pulse; rnd is valid and belongs to the gnt owner.
- busy  output  1  high whenever state is not IDLE.

## Operation
- LFSR step: next = {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? TAPS : 0).
- Sequence from all-ones with defaults: F,D,9,1,2,4,8,3,6,C,B,5,A,7,E, then F again.
- Reset values:
  - lfsr = all ones; state = IDLE; cnt = 0.
  - last = 1, so requester 0 wins the first tie.
  - gnt = 0; rnd = 0; rnd_vld = 0; busy = 0.
- States: IDLE, STEP, DELIVER.
- IDLE:
  - seed_we = 1: lfsr <= seed, or all-ones if seed == 0 (zero-lock guard). Stay in IDLE. Any req in the same cycle is ignored.
  - Otherwise, if any req: pick owner, load cnt <= STEPS-1, go to STEP.
  - Arbitration: a single requester wins outright. If both request, the winner is the requester that is not `last`.
- STEP:
  - lfsr advances once per cycle.
  - If cnt == 0: rnd <= lfsr_next, go to DELIVER. Otherwise cnt <= cnt-1.
  - Exactly STEPS advances occur per grant.
- DELIVER (one cycle):
  - gnt[owner] = 1, rnd_vld = 1, last <= owner.
  - Return to IDLE unconditionally.
- gnt, rnd_vld and busy are decoded from registered state and owner only, never from inputs.
- seed_we outside IDLE is dropped, not queued. lfsr is unaffected.
- If req drops during STEP, the transaction still completes and the gnt/rnd_vld pulse still occurs.
- lfsr can never reach 0: TAPS[0] = 1, and the seed guard blocks a zero seed.

## Timing
- Request sampled at the end of IDLE cycle 0.
- STEP occupies cycles 1..STEPS.
- DELIVER is cycle STEPS+1, with gnt and rnd_vld high.
- Cycle STEPS+2 is IDLE, where the next request can be sampled.
- Throughput: one value per STEPS+2 cycles (6 with defaults).
- The requester must deassert req in the cycle after its gnt. Otherwise it re-requests, and round-robin favours the other requester on a tie.
- Seed load takes effect on the next edge. A request in the following IDLE cycle steps from the new seed.
- Asserting rst_b low at any time, including mid-STEP or during DELIVER, immediately forces all reset values. gnt and rnd_vld drop without waiting for a clock edge. No partial transaction resumes after reset.

## Test plan
- **Single request:** after reset, req=01 for one IDLE cycle.
  - Expect busy=1 for 5 cycles.
  - Expect gnt=01 and rnd_vld=1 on cycle 5, with rnd=4'h2 (F→D→9→1→2).
- **Back-to-back requests:** req=01 again after the first delivery.
  - Expect rnd=4'h6 (2→4→8→3→6), delivered 6 cycles after the first.
- **Fairness:** from reset, hold req=11 and drop each bit after its grant.
  - Expect grants in order 01 (rnd 2), then 10 (rnd 6), then 01 (rnd A) if bit 0 is re-raised.
- **Seeding:**
  - seed_we=1, seed=8 in IDLE, then req=10: expect rnd=4'hB (8→3→6→C→B) and gnt=10.
  - seed_we=1, seed=0: lfsr reloads F, and the next delivery is 2.
- **Seed while busy and simultaneous seed/request:**
  - seed_we pulsed during STEP: ignored, delivery value unchanged.
  - seed_we and req together in IDLE: seed loads, no grant that cycle, the request is served next cycle.
- **Reset mid-operation:** pull rst_b low during the third STEP cycle.
  - Expect busy=0, gnt=0, rnd=0 and lfsr=F immediately.
  - After release with req=01, expect rnd=2.
